dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencing arbiter for the byte-organised data memory. Two requesters share one byte-wide, single-port, synchronous-read memory: port 0 is the core load/store path and port 1 is a debug/DMA port. The block picks a requester round-robin and splits each access into 1, 2 or 4 byte beats. It assembles loads with RV32 sign/zero extension and returns a one-cycle response pulse.

## Interface
- MEM_BYTES, 2000: memory size in bytes. Any access whose last byte falls at or beyond this limit is an error.
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iReq0 / iReq1  in  1  access request, per port.
- iAddr0 / iAddr1  in  32  byte base address.
- iWdata0 / iWdata1  in  32  store data; bytes are taken from the LSB upward.
- iFunct3_0 / iFunct3_1  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- iWe0 / iWe1  in  1  1 = store, 0 = load.
- oGnt0 / oGnt1  out  1  one-cycle acceptance pulse.
- oRvalid0 / oRvalid1  out  1  one-cycle completion pulse; asserted for both loads and stores.
- oRdata  out  32  load result; qualified by either oRvalid.
- oErr  out  1  error flag; qualified by either oRvalid.
- oBusy  out  1  high whenever the state is not IDLE.
- oMemEn  out  1  byte memory access strobe.
- oMemWe  out  1  byte write enable; only ever high while oMemEn is high.
- oMemAddr  out  32  byte address.
- oMemWdata  out  8  write byte.
- iMemRdata  in  8  read byte; valid the cycle after an oMemEn cycle with oMemWe = 0.

## Operation
- **States:** IDLE, BEAT, CAPT.
- **Arbitration:** runs only in IDLE.
  - One request pending: that port wins.
  - Both pending: the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- **Request latch:** on acceptance, latch the winner's addr, wdata, funct3, we and the port id.
  - Set beat count n: 1 for funct3 000/100, 2 for 001/101, 4 for 010.
  - Clear the beat index k.
- **Request validation:**
  - Illegal funct3 (011, 110, 111) sets the error flag.
  - Range violation (base + n − 1 ≥ MEM_BYTES, computed in 33 bits so there is no wrap) sets the error flag.
  - An error access goes IDLE→CAPT, issues no memory beats, and returns oRdata = 0 with oErr = 1.
- **BEAT state:** one byte per cycle.
  - oMemEn = 1, oMemAddr = base + k, oMemWe = we, oMemWdata = wdata[8k+7:8k].
  - k increments each cycle; the last beat (k = n−1) moves to CAPT.
- **Load capture:** on loads, iMemRdata is captured into byte lane k−1 of the assembly register on every BEAT cycle with k ≥ 1. The final byte is captured in CAPT.
- **CAPT state:** always returns to IDLE. Loads form the result on the way:
  - b / h: sign-extend from bit 7 / bit 15.
  - bu / hu: zero-extend.
  - Stores: oRdata = 0.
- **Response:** oRvalid of the latched port is registered and pulses in the first IDLE cycle after CAPT. oRdata and oErr hold their values until the next response.
- **Request holding:** a requester holds iReq and its operands stable until it sees oGnt.
  - Any iReq still high while the block is in IDLE counts as a new request.
  - iReq seen during BEAT or CAPT is ignored.
- **Reset values:**
  - State IDLE, last-grant pointer = 1.
  - All oGnt, oRvalid, oMemEn and oMemWe = 0.
  - oRdata = 0, oErr = 0, oMemAddr = 0, oMemWdata = 0.
- **Reset mid-operation:** abort at the reset edge. oMemEn and oMemWe are 0 from the next cycle. The aborted access gets no oRvalid.

## Timing
- Request sampled in IDLE in cycle T:
  - oGnt is high in cycle T+1 only.
  - Beats occupy cycles T+1 .. T+n.
  - CAPT is cycle T+n+1.
  - oRvalid is high in cycle T+n+2.
- End-to-end latency from request to response: byte 3 cycles, half 4, word 6. Error accesses take 2.
- A new request can be accepted in the same cycle that oRvalid is high, giving back-to-back throughput of n+2 cycles per access.
- **Memory read data:** the byte addressed in cycle t appears on iMemRdata in cycle t+1 and is captured at the end of t+1.
- **Outputs:** all outputs are registered except oBusy, which is decoded from the state register.

## Test plan
- **Word store then word load, port 0, addr 0x10:** store data 0xA1B2C3D4. Required bytes written: addr 0x10..0x13 = D4, C3, B2, A1. The load returns 0xA1B2C3D4 with oRvalid0 at T+6.
- **Byte load from a location holding 0x80:** lb returns 0xFFFFFF80; lbu returns 0x00000080; both take 3 cycles.
- **Half load from 0x21:** 0x21 = 0x34, 0x22 = 0xF2. lh returns 0xFFFFF234; lhu returns 0x0000F234. Unaligned access is legal and uses 2 beats.
- **Round-robin:** iReq0 and iReq1 are both held continuously for 4 requests. Required grant order: 0, 1, 0, 1. Each oRvalid goes to the matching port, and the two ports' accesses never overlap.
- **Errors:**
  - Word access at addr 1997 (MEM_BYTES = 2000) returns oErr = 1 and oRdata = 0 at T+2, with oMemEn never asserted.
  - funct3 = 011 gives the same error result.
- **Reset mid-operation:** iRst asserted during beat 2 of a word store. From the next cycle: state IDLE, oMemWe = 0, oMemEn = 0, and no oRvalid. A subsequent tie is granted to port 0.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - requester, response and byte-memory bus signals of the data memory arbiter
interface dmem_access_ctrl_if;
  logic        iReq0;
  logic        iReq1;
  logic [31:0] iAddr0;
  logic [31:0] iAddr1;
  logic [31:0] iWdata0;
  logic [31:0] iWdata1;
  logic [2:0]  iFunct3_0;
  logic [2:0]  iFunct3_1;
  logic        iWe0;
  logic        iWe1;
  logic        oGnt0;
  logic        oGnt1;
  logic        oRvalid0;
  logic        oRvalid1;
  logic [31:0] oRdata;
  logic        oErr;
  logic        oBusy;
  logic        oMemEn;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [7:0]  oMemWdata;
  logic [7:0]  iMemRdata;

  modport slave (
    input  iReq0, iReq1, iAddr0, iAddr1, iWdata0, iWdata1,
    input  iFunct3_0, iFunct3_1, iWe0, iWe1, iMemRdata,
    output oGnt0, oGnt1, oRvalid0, oRvalid1, oRdata, oErr, oBusy,
    output oMemEn, oMemWe, oMemAddr, oMemWdata
  );

  modport master (
    output iReq0, iReq1, iAddr0, iAddr1, iWdata0, iWdata1,
    output iFunct3_0, iFunct3_1, iWe0, iWe1, iMemRdata,
    input  oGnt0, oGnt1, oRvalid0, oRvalid1, oRdata, oErr, oBusy,
    input  oMemEn, oMemWe, oMemAddr, oMemWdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - round-robin two-port arbiter splitting RV32 accesses into byte beats
module dmem_access_ctrl #(
  parameter int MEM_BYTES = 2000
) (
  input logic               iClk,
  input logic               iRst,
  dmem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT, CAPT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last;
  logic        r_port;
  logic [31:0] r_addr, r_wdata, r_asm;
  logic [2:0]  r_funct3, r_n, r_k;
  logic        r_we, r_err;
  logic        r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_oerr;
  logic [31:0] r_rdata, r_mem_addr;
  logic        r_mem_en, r_mem_we;
  logic [7:0]  r_mem_wdata;

  logic        w_accept, w_win, w_sel_we, w_illegal, w_sel_err, w_last_beat;
  logic [31:0] w_sel_addr, w_sel_wdata, w_full, w_result;
  logic [2:0]  w_sel_funct3, w_sel_n, w_k_next;
  logic [32:0] w_end;
  logic [7:0]  w_beat_byte;

  // Arbitrate in IDLE, pick the winner's operands and validate width code and range
  always_comb begin
    w_accept = 1'b0;
    w_win    = 1'b0;
    if (r_state == IDLE) begin
      if (bus.iReq0 && bus.iReq1) begin
        w_accept = 1'b1;
        w_win    = ~r_last;
      end else if (bus.iReq0) begin
        w_accept = 1'b1;
      end else if (bus.iReq1) begin
        w_accept = 1'b1;
        w_win    = 1'b1;
      end
    end
    w_sel_addr   = w_win ? bus.iAddr1 : bus.iAddr0;
    w_sel_wdata  = w_win ? bus.iWdata1 : bus.iWdata0;
    w_sel_funct3 = w_win ? bus.iFunct3_1 : bus.iFunct3_0;
    w_sel_we     = w_win ? bus.iWe1 : bus.iWe0;
    w_illegal    = 1'b0;
    case (w_sel_funct3)
      3'b000, 3'b100: w_sel_n = 3'd1;
      3'b001, 3'b101: w_sel_n = 3'd2;
      3'b010:         w_sel_n = 3'd4;
      default: begin
        w_sel_n   = 3'd1;
        w_illegal = 1'b1;
      end
    endcase
    // 33-bit end address so a base near 2^32 cannot wrap into range
    w_end     = {1'b0, w_sel_addr} + {30'd0, w_sel_n} - 33'd1;
    w_sel_err = w_illegal || (w_end >= 33'(MEM_BYTES));
  end

  // Next state: errors skip the beats and go straight to the response stage
  always_comb begin
    w_state_nxt = r_state;
    w_last_beat = (r_k == r_n - 3'd1);
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_sel_err ? CAPT : BEAT;
      BEAT: if (w_last_beat) w_state_nxt = CAPT;
      CAPT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Load result: final byte arrives in CAPT, then sign/zero extension by width code
  always_comb begin
    w_k_next    = r_k + 3'd1;
    w_beat_byte = 8'(r_wdata >> {w_k_next, 3'b000});
    w_full      = r_asm;
    case (r_n)
      3'd1:    w_full[7:0]   = bus.iMemRdata;
      3'd2:    w_full[15:8]  = bus.iMemRdata;
      default: w_full[31:24] = bus.iMemRdata;
    endcase
    case (r_funct3)
      3'b000:  w_result = {{24{w_full[7]}}, w_full[7:0]};
      3'b001:  w_result = {{16{w_full[15]}}, w_full[15:0]};
      3'b100:  w_result = {24'd0, w_full[7:0]};
      3'b101:  w_result = {16'd0, w_full[15:0]};
      default: w_result = w_full;
    endcase
    if (r_we || r_err) w_result = 32'd0;
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Request latch, beat sequencing, load assembly and registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_last      <= 1'b1;
      r_port      <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_asm       <= 32'd0;
      r_funct3    <= 3'd0;
      r_n         <= 3'd1;
      r_k         <= 3'd0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_oerr      <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_last      <= w_win;
            r_port      <= w_win;
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_funct3    <= w_sel_funct3;
            r_we        <= w_sel_we;
            r_n         <= w_sel_n;
            r_k         <= 3'd0;
            r_err       <= w_sel_err;
            r_asm       <= 32'd0;
            r_gnt0      <= ~w_win;
            r_gnt1      <= w_win;
            r_mem_en    <= ~w_sel_err;
            r_mem_we    <= ~w_sel_err & w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata[7:0];
          end
        end
        BEAT: begin
          // Byte read in the previous beat is on iMemRdata now
          if (!r_we) begin
            case (r_k)
              3'd1:    r_asm[7:0]   <= bus.iMemRdata;
              3'd2:    r_asm[15:8]  <= bus.iMemRdata;
              3'd3:    r_asm[23:16] <= bus.iMemRdata;
              default: ;
            endcase
          end
          if (w_last_beat) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
          end else begin
            r_k         <= w_k_next;
            r_mem_addr  <= r_addr + {29'd0, w_k_next};
            r_mem_wdata <= w_beat_byte;
          end
        end
        CAPT: begin
          r_rdata   <= w_result;
          r_oerr    <= r_err;
          r_rvalid0 <= ~r_port;
          r_rvalid1 <= r_port;
        end
        default: ;
      endcase
    end
  end

  assign bus.oGnt0     = r_gnt0;
  assign bus.oGnt1     = r_gnt1;
  assign bus.oRvalid0  = r_rvalid0;
  assign bus.oRvalid1  = r_rvalid1;
  assign bus.oRdata    = r_rdata;
  assign bus.oErr      = r_oerr;
  assign bus.oBusy     = (r_state != IDLE);
  assign bus.oMemEn    = r_mem_en;
  assign bus.oMemWe    = r_mem_we;
  assign bus.oMemAddr  = r_mem_addr;
  assign bus.oMemWdata = r_mem_wdata;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl with byte memory and reference model
module tb_dmem_access_ctrl;
  localparam int MEM_BYTES = 2000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        we;
  } req_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          beats;
  } exp_t;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  dmem_access_ctrl_if bus();
  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));

  logic [7:0] dut_mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  req_t stim_q0[$];
  req_t stim_q1[$];
  exp_t sb[$];
  int   gnt_log[$];
  req_t cur0, cur1;
  logic pend0 = 1'b0, pend1 = 1'b0;
  logic model_last = 1'b1;
  int   req_pct = 100;
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   beats = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  // Byte-wide synchronous-read memory seen by the DUT
  always @(posedge iClk) begin
    if (bus.oMemEn && bus.oMemAddr < MEM_BYTES) begin
      if (bus.oMemWe) dut_mem[bus.oMemAddr[10:0]] <= bus.oMemWdata;
      else            bus.iMemRdata <= dut_mem[bus.oMemAddr[10:0]];
    end
  end

  // Reference: whole access applied at once, value formed arithmetically
  function automatic void model(input req_t r, output logic [31:0] rd, output logic err, output int n);
    logic   illegal;
    longint last;
    logic [31:0] v;
    illegal = 1'b0;
    case (r.f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default: begin n = 1; illegal = 1'b1; end
    endcase
    last = longint'(r.addr) + n - 1;
    err  = illegal || (last >= MEM_BYTES);
    rd   = 32'd0;
    if (!err) begin
      if (r.we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(r.addr) + i] = r.wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v + (32'(ref_mem[int'(r.addr) + i]) << (8 * i));
        rd = v;
        if (r.f3 == 3'd0 && v >= 32'h80)   rd = v - 32'h100;
        if (r.f3 == 3'd1 && v >= 32'h8000) rd = v - 32'h10000;
      end
    end
  endfunction

  function automatic req_t mk(input logic [31:0] a, input logic [2:0] f, input logic w, input logic [31:0] d);
    req_t r;
    r.addr = a; r.f3 = f; r.we = w; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [2:0] codes [10];
    codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    if ($urandom_range(99) < 5) r.addr = 32'hFFFFFFF0 + 32'($urandom_range(15));
    else                        r.addr = 32'($urandom_range(MEM_BYTES + 5));
    r.f3    = codes[$urandom_range(9)];
    r.we    = 1'($urandom_range(1));
    r.wdata = $urandom;
    return r;
  endfunction

  // One cycle of requester behaviour: observe grants, then raise new requests
  task automatic step();
    exp_t e;
    logic [31:0] rd;
    logic er;
    int n, p, exp_p;
    req_t r;
    @(negedge iClk);
    if (bus.oGnt0 || bus.oGnt1) begin
      p     = bus.oGnt1 ? 1 : 0;
      exp_p = (pend0 && pend1) ? int'(!model_last) : (pend1 ? 1 : 0);
      checks++;
      if ((bus.oGnt0 && bus.oGnt1) || p != exp_p || !(p == 1 ? pend1 : pend0)) begin
        errors++;
        $display("FAIL grant_port got gnt0=%0b gnt1=%0b required port %0d", bus.oGnt0, bus.oGnt1, exp_p);
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL overlap got %0d outstanding at grant required 0", sb.size());
      end
      r = (p == 1) ? cur1 : cur0;
      model(r, rd, er, n);
      e.port = p; e.rdata = rd; e.err = er;
      e.due = cyc + (er ? 1 : n + 1);
      e.beats = er ? 0 : n;
      sb.push_back(e);
      gnt_log.push_back(p);
      model_last = p[0];
      if (p == 1) begin pend1 = 1'b0; bus.iReq1 = 1'b0; end
      else        begin pend0 = 1'b0; bus.iReq0 = 1'b0; end
    end
    if (!pend0 && stim_q0.size() > 0 && $urandom_range(99) < req_pct) begin
      cur0 = stim_q0.pop_front();
      bus.iAddr0 = cur0.addr; bus.iWdata0 = cur0.wdata; bus.iFunct3_0 = cur0.f3; bus.iWe0 = cur0.we;
      bus.iReq0 = 1'b1; pend0 = 1'b1;
    end
    if (!pend1 && stim_q1.size() > 0 && $urandom_range(99) < req_pct) begin
      cur1 = stim_q1.pop_front();
      bus.iAddr1 = cur1.addr; bus.iWdata1 = cur1.wdata; bus.iFunct3_1 = cur1.f3; bus.iWe1 = cur1.we;
      bus.iReq1 = 1'b1; pend1 = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((stim_q0.size() > 0 || stim_q1.size() > 0 || pend0 || pend1 || sb.size() > 0) && t < budget) begin
      step();
      t++;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d outstanding after %0d cycles required 0", sb.size(), t);
    end
    step();
  endtask

  // Response monitor: pops the scoreboard on every oRvalid
  always @(negedge iClk) begin
    exp_t e;
    if (!iRst) begin
      if (bus.oMemWe) begin
        checks++;
        if (!bus.oMemEn) begin errors++; $display("FAIL memwe_without_en got en=0 required en=1"); end
      end
      if (bus.oRvalid0 || bus.oRvalid1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid got rvalid0=%0b rvalid1=%0b required none", bus.oRvalid0, bus.oRvalid1);
        end else begin
          e = sb.pop_front();
          if ((bus.oRvalid0 && bus.oRvalid1) || (bus.oRvalid1 ? 1 : 0) != e.port) begin
            errors++;
            $display("FAIL rvalid_port got rvalid0=%0b rvalid1=%0b required port %0d", bus.oRvalid0, bus.oRvalid1, e.port);
          end
          checks++;
          if (bus.oRdata !== e.rdata) begin errors++; $display("FAIL rdata got %08h required %08h", bus.oRdata, e.rdata); end
          checks++;
          if (bus.oErr !== e.err) begin errors++; $display("FAIL err got %0b required %0b", bus.oErr, e.err); end
          checks++;
          if (cyc != e.due) begin errors++; $display("FAIL latency got cycle %0d required cycle %0d", cyc, e.due); end
          checks++;
          if (beats != e.beats) begin errors++; $display("FAIL mem_beats got %0d required %0d", beats, e.beats); end
        end
      end
      if (bus.oGnt0 || bus.oGnt1) beats = bus.oMemEn ? 1 : 0;
      else if (bus.oMemEn)        beats = beats + 1;
    end
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] keep;
    int t, bad;
    iRst = 1'b1;
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    bus.iAddr0 = 32'd0; bus.iAddr1 = 32'd0; bus.iWdata0 = 32'd0; bus.iWdata1 = 32'd0;
    bus.iFunct3_0 = 3'd0; bus.iFunct3_1 = 3'd0; bus.iWe0 = 1'b0; bus.iWe1 = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      b = 8'($urandom);
      dut_mem[i] = b; ref_mem[i] = b;
    end
    dut_mem[32'h40] = 8'h80; ref_mem[32'h40] = 8'h80;
    dut_mem[32'h21] = 8'h34; ref_mem[32'h21] = 8'h34;
    dut_mem[32'h22] = 8'hF2; ref_mem[32'h22] = 8'hF2;

    repeat (3) @(negedge iClk);
    checks++;
    if ({bus.oGnt0, bus.oGnt1, bus.oRvalid0, bus.oRvalid1, bus.oErr, bus.oBusy, bus.oMemEn, bus.oMemWe} !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got %08b required 00000000",
               {bus.oGnt0, bus.oGnt1, bus.oRvalid0, bus.oRvalid1, bus.oErr, bus.oBusy, bus.oMemEn, bus.oMemWe});
    end
    checks++;
    if (bus.oRdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %08h required 0", bus.oRdata); end
    checks++;
    if (bus.oMemAddr !== 32'd0 || bus.oMemWdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_membus got addr=%08h wdata=%02h required 0", bus.oMemAddr, bus.oMemWdata);
    end
    iRst = 1'b0;

    // Both ports held for four requests: grants alternate starting with port 0
    gnt_log.delete();
    stim_q0.push_back(mk(32'h100, 3'd2, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'h104, 3'd2, 1'b0, 32'd0));
    stim_q1.push_back(mk(32'h200, 3'd0, 1'b0, 32'd0));
    stim_q1.push_back(mk(32'h201, 3'd1, 1'b0, 32'd0));
    drain(200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt_log.size() <= i || gnt_log[i] != (i % 2)) begin
        errors++;
        $display("FAIL rr_order index %0d got %0d required %0d", i, (gnt_log.size() > i) ? gnt_log[i] : -1, i % 2);
      end
    end

    // Directed port-0 accesses including signed/unsigned, unaligned and error cases
    stim_q0.push_back(mk(32'h10, 3'd2, 1'b1, 32'hA1B2C3D4));
    stim_q0.push_back(mk(32'h10, 3'd2, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'h40, 3'd0, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'h40, 3'd4, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'h21, 3'd1, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'h21, 3'd5, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'd1997, 3'd2, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'd0, 3'd3, 1'b0, 32'd0));
    stim_q0.push_back(mk(32'd1999, 3'd0, 1'b1, 32'h5A));
    stim_q1.push_back(mk(32'd1998, 3'd5, 1'b0, 32'd0));
    drain(400);
    checks++;
    if ({dut_mem[32'h13], dut_mem[32'h12], dut_mem[32'h11], dut_mem[32'h10]} !== 32'hA1B2C3D4) begin
      errors++;
      $display("FAIL store_bytes got %02h%02h%02h%02h required a1b2c3d4",
               dut_mem[32'h13], dut_mem[32'h12], dut_mem[32'h11], dut_mem[32'h10]);
    end

    // Reset during the second beat of a word store (data equal to current contents)
    gnt_log.delete();
    keep = {ref_mem[32'h303], ref_mem[32'h302], ref_mem[32'h301], ref_mem[32'h300]};
    stim_q0.push_back(mk(32'h300, 3'd2, 1'b1, keep));
    t = 0;
    while (gnt_log.size() == 0 && t < 20) begin step(); t++; end
    checks++;
    if (gnt_log.size() == 0) begin errors++; $display("FAIL reset_test_grant got none required port 0"); end
    @(negedge iClk);
    iRst = 1'b1;
    sb.delete();
    @(negedge iClk);
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oMemEn !== 1'b0 || bus.oMemWe !== 1'b0 || bus.oRvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got busy=%0b en=%0b we=%0b rvalid0=%0b required 0000",
               bus.oBusy, bus.oMemEn, bus.oMemWe, bus.oRvalid0);
    end
    iRst = 1'b0;
    model_last = 1'b1;
    repeat (8) step();
    gnt_log.delete();
    stim_q0.push_back(mk(32'h30, 3'd0, 1'b0, 32'd0));
    stim_q1.push_back(mk(32'h31, 3'd0, 1'b0, 32'd0));
    drain(100);
    checks++;
    if (gnt_log.size() == 0 || gnt_log[0] != 0) begin
      errors++;
      $display("FAIL tie_after_reset got %0d required 0", (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end

    // Random traffic from both ports
    req_pct = 40;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(1) == 0) stim_q0.push_back(rand_req());
      else                        stim_q1.push_back(rand_req());
    end
    drain(20000);

    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mem_contents got %0d differing bytes required 0", bad); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
